// File: rtl/bin2gc_pkg.sv
// Shared constants and the binary-to-Gray helper for the bin2gc counter.
// Optional feature macro used by this slice: BIN2GC_WRAP_FLAG_EN.
package bin2gc_pkg;

    localparam int BIN2GC_DEFAULT_WIDTH = 4;

    // Width argument masks off bits above the counter width.
    function automatic logic [31:0] bin_to_gray(input logic [31:0] value, input int unsigned width);
        logic [31:0] mask_v;
        mask_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value ^ (value >> 1)) & mask_v;
    endfunction

endpackage

// File: rtl/bin2gc_if.sv
// Enable/Gray-count bundle between the counter and its consumer.
// With BIN2GC_WRAP_FLAG_EN defined the bundle also carries the wrap pulse.
interface bin2gc_if
    import bin2gc_pkg::*;
#(
    parameter int WIDTH = BIN2GC_DEFAULT_WIDTH
);

    logic             en;
    logic [WIDTH-1:0] gray;
`ifdef BIN2GC_WRAP_FLAG_EN
    logic             wrap;

    modport master (output en, input gray, input wrap);
    modport slave  (input en, output gray, output wrap);
`else
    modport master (output en, input gray);
    modport slave  (input en, output gray);
`endif

endinterface

// File: rtl/bin2gray_conv.sv
// Purely combinational WIDTH-bit binary-to-Gray converter.
module bin2gray_conv
    import bin2gc_pkg::*;
#(
    parameter int WIDTH = BIN2GC_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Convert through the shared package helper so all users agree on encoding.
    always_comb begin
        gray = WIDTH'(bin_to_gray(32'(bin), WIDTH));
    end

endmodule

// File: rtl/bin2gc.sv
// Free-running Gray-code counter with enable; gray is taken straight from a register.
// Define BIN2GC_WRAP_FLAG_EN to add a registered one-cycle wrap pulse.
module bin2gc
    import bin2gc_pkg::*;
#(
    parameter int WIDTH = BIN2GC_DEFAULT_WIDTH
) (
    input  logic     clk,
    input  logic     rst_,
    bin2gc_if.slave  bus
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_n_s;
    logic [WIDTH-1:0] gray_n_s;

    // Next binary value; the add wraps naturally modulo 2^WIDTH.
    always_comb begin
        bin_n_s = bin_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    bin2gray_conv #(
        .WIDTH (WIDTH)
    ) u_conv (
        .bin  (bin_n_s),
        .gray (gray_n_s)
    );

    // Counter and Gray output registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst_) begin
            bin_q  <= {WIDTH{1'b0}};
            gray_q <= {WIDTH{1'b0}};
        end else if (bus.en) begin
            bin_q  <= bin_n_s;
            gray_q <= gray_n_s;
        end else begin
            bin_q  <= bin_q;
            gray_q <= gray_q;
        end
    end

    assign bus.gray = gray_q;

`ifdef BIN2GC_WRAP_FLAG_EN
    logic wrap_q;

    // Pulse for one cycle after an enabled step out of the all-ones count.
    always_ff @(posedge clk) begin
        if (rst_) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= bus.en && (&bin_q);
        end
    end

    assign bus.wrap = wrap_q;
`endif

endmodule

// File: tb/tb_bin2gc.sv
// Directed self-checking bench for bin2gc at WIDTH 4 (main), 2 and 8 (sweep).
// Wrap-pulse checks are compiled in when BIN2GC_WRAP_FLAG_EN is defined.
module tb_bin2gc;

    logic clk;
    logic rst_;
    int   checks;
    int   failures;

    bin2gc_if #(.WIDTH(4)) if4 ();
    bin2gc_if #(.WIDTH(2)) if2 ();
    bin2gc_if #(.WIDTH(8)) if8 ();

    bin2gc #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_(rst_), .bus(if4));
    bin2gc #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_(rst_), .bus(if2));
    bin2gc #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_(rst_), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed 4-bit Gray sequence starting after 0.
    logic [3:0] seq4 [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0111, 4'b0101, 4'b0100, 4'b1100,
                              4'b1101, 4'b1111, 4'b1110, 4'b1010,
                              4'b1011, 4'b1001, 4'b1000, 4'b0000};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e);
        rst_   = r;
        if4.en = e;
        if2.en = e;
        if8.en = e;
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  prev4;
        logic [1:0]  m2, p2;
        logic [7:0]  m8, p8;
        int          wrap_cnt;

        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0);

        // Reset, then reset held with enable high.
        step();
        check_eq("reset_gray4", 32'(if4.gray), 32'd0);
        drive(1'b1, 1'b1);
        step();
        check_eq("reset_en_gray4", 32'(if4.gray), 32'd0);
        check_eq("reset_en_gray2", 32'(if2.gray), 32'd0);
        check_eq("reset_en_gray8", 32'(if8.gray), 32'd0);
`ifdef BIN2GC_WRAP_FLAG_EN
        check_eq("reset_wrap4", 32'(if4.wrap), 32'd0);
`endif

        // First eight counts.
        drive(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq($sformatf("count_%0d", k), 32'(if4.gray), 32'(seq4[k]));
        end

        // Full 16-step cycle from zero, including the wrap step.
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1);
        prev4    = 4'b0000;
        wrap_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            check_eq($sformatf("wrap_seq_%0d", k), 32'(if4.gray), 32'(seq4[k]));
            check_eq($sformatf("hamming_%0d", k), 32'($countones(if4.gray ^ prev4)), 32'd1);
            prev4 = if4.gray;
`ifdef BIN2GC_WRAP_FLAG_EN
            check_eq($sformatf("wrap_flag_%0d", k), 32'(if4.wrap), (k == 15) ? 32'd1 : 32'd0);
            if (if4.wrap) wrap_cnt = wrap_cnt + 1;
`endif
        end
`ifdef BIN2GC_WRAP_FLAG_EN
        check_eq("wrap_pulses", 32'(wrap_cnt), 32'd1);
`endif

        // Enable hold at 0110, then resume.
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step();
        check_eq("hold_start", 32'(if4.gray), 32'b0110);
        drive(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq($sformatf("hold_%0d", k), 32'(if4.gray), 32'b0110);
        end
        drive(1'b0, 1'b1);
        step();
        check_eq("resume", 32'(if4.gray), 32'b0111);

        // Reset in the middle of counting.
        step();
        check_eq("mid_pre", 32'(if4.gray), 32'b0101);
        drive(1'b1, 1'b1);
        step();
        check_eq("mid_reset", 32'(if4.gray), 32'd0);
        drive(1'b0, 1'b1);
        step();
        check_eq("mid_restart", 32'(if4.gray), 32'b0001);

        // Width sweep: 2^8+1 enabled steps, all widths against a bench counter.
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1);
        m2 = 2'd0;
        m8 = 8'd0;
        for (int k = 1; k <= 257; k++) begin
            p2 = m2 ^ (m2 >> 1);
            p8 = m8 ^ (m8 >> 1);
            m2 = m2 + 2'd1;
            m8 = m8 + 8'd1;
            step();
            check_eq($sformatf("w2_%0d", k), 32'(if2.gray), 32'(m2 ^ (m2 >> 1)));
            check_eq($sformatf("w8_%0d", k), 32'(if8.gray), 32'(m8 ^ (m8 >> 1)));
            check_eq($sformatf("w2_ham_%0d", k), 32'($countones(if2.gray ^ p2)), 32'd1);
            check_eq($sformatf("w8_ham_%0d", k), 32'($countones(if8.gray ^ p8)), 32'd1);
`ifdef BIN2GC_WRAP_FLAG_EN
            check_eq($sformatf("w2_wrap_%0d", k), 32'(if2.wrap), (m2 == 2'd0) ? 32'd1 : 32'd0);
            check_eq($sformatf("w8_wrap_%0d", k), 32'(if8.wrap), (m8 == 8'd0) ? 32'd1 : 32'd0);
`endif
            if (k == 255) check_eq("w8_last", 32'(if8.gray), 32'h80);
            if (k == 256) check_eq("w8_zero", 32'(if8.gray), 32'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2gc.md
Name: bin2gc

Overview:
- Free-running Gray-code counter with enable; output is a registered Gray-encoded count.
- Internally it keeps a binary counter and converts the next binary value to Gray before registering it.
- The output is glitch-free, and only one bit changes per increment.
- Used as a pointer/sequence source, e.g. for clock-domain-crossing FIFO pointers and status sequencing.

Parameters:
- WIDTH, 4, counter and Gray output width in bits; legal range is 2 to 32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_  input  1  synchronous, active-high reset. Despite the trailing underscore, a 1 sampled at the clk rising edge resets the block.
- en  input  1  count enable; sampled at the clk rising edge.
- gray  output  WIDTH  registered Gray-coded count.

Behaviour:
- State:
  - bin_q[WIDTH-1:0]: internal binary count.
  - gray_q[WIDTH-1:0]: drives the gray output directly, with no combinational path from any input.
- Reset: at a rising edge with rst_=1, bin_q<=0 and gray_q<=0. Reset has priority over en. While rst_ is held high, the outputs stay 0 regardless of en.
- Count: at a rising edge with rst_=0 and en=1:
  - bin_q<=bin_q+1, modulo 2^WIDTH.
  - gray_q<=bin_n ^ (bin_n>>1), where bin_n=bin_q+1.
- Hold: at a rising edge with rst_=0 and en=0, both registers keep their values.
- Invariant: gray == bin_q ^ (bin_q>>1) at all times after the first reset.
- Latency: gray reflects an enabled increment one clock after en is sampled high. There are no added pipeline stages.
- Wrap-around, WIDTH=4: bin 15 -> 0, and gray 1000 -> 0000. This is a single-bit change with no special casing.
- Single-bit-change property: every enabled step changes exactly one bit of gray, including the wrap step. An en=0 cycle changes no bits.
- Reset mid-count: the next edge with rst_=1 forces 0. Counting resumes from 0 (gray 0001 on the first enabled edge after rst_ deasserts).
- Power-up: there is no defined value before the first reset. The bench must apply reset first.
- No handshake and no backpressure.

Optional Feature:
- Macro: BIN2GC_WRAP_FLAG_EN.
- When defined:
  - Adds output port wrap (1 bit, registered).
  - wrap is 1 for exactly one cycle following an enabled edge where bin_q was all ones (the gray all-ones-to-zero transition), and 0 otherwise.
  - Reset clears wrap to 0.
- When undefined: the wrap port and its logic are absent, and the block behaves exactly as described above.

Decomposition:
- Package bin2gc_pkg:
  - constant BIN2GC_DEFAULT_WIDTH = 4;
  - function bin_to_gray(value, width) returning value ^ (value>>1).
- One natural sub-module: bin2gray_conv, a purely combinational WIDTH-parameterised binary-to-Gray converter.
  - The top level instantiates it on bin_n and registers its output into gray_q.

Test Plan:
- Reset: en=0, rst_=1 for 1 cycle -> gray=0000. Then en=1 with rst_ still 1 -> gray stays 0000.
- Count sequence: rst_=0, en=1 for 8 cycles -> gray steps 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
- Wrap: en=1 for 16 cycles from 0 -> 15th value is 1000, 16th is 0000. Checker confirms Hamming distance 1 between all successive enabled values. With BIN2GC_WRAP_FLAG_EN defined, wrap pulses exactly once, aligned with gray=0000.
- Enable hold: count to 0110, then en=0 for 5 cycles -> gray holds 0110. Re-enable -> 0111 on the next edge.
- Reset mid-count: at gray=0101, assert rst_=1 for 1 cycle with en=1 -> gray=0000. Release -> next enabled edge gives 0001.
- Width sweep: WIDTH=2 and WIDTH=8, en=1 for 2^WIDTH+1 cycles -> full Gray cycle observed, wrap back to 0, invariant holds every cycle.
